// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the MIPS pipeline slice.
//   - default datapath / register-specifier widths
//   - bit positions inside the 9-bit control bundle
//     {RegWrite,MemtoReg,MemRead,MemWrite,ALUSrc,RegDst,Branch,ALUOp[1:0]}
//   - the NOP control bundle used for pipeline bubbles
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 9;

    localparam int CTRL_REGWRITE = 8;
    localparam int CTRL_MEMTOREG = 7;
    localparam int CTRL_MEMREAD  = 6;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_REGDST   = 3;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_ALUOP    = 0;   // low bit of the 2-bit ALUOp field

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use hazard detection.
// Ports:
//   idex_memread  in   instruction in EX is a load
//   idex_rt       in   destination of that load
//   ifid_rs       in   rs of the instruction in ID
//   ifid_rt       in   rt of the instruction in ID
//   ifid_uses_rt  in   ID instruction reads rt as a source
//   flush         in   redirect in progress; suppresses the stall
//   hazard_stall  out  1 = insert a bubble this cycle
//   pc_write      out  0 = hold PC
//   ifid_write    out  0 = hold IF/ID
module hazard_detect
    import mips_pkg::*;
#(
    parameter int REG_AW_P = REG_AW
) (
    input  logic              idex_memread,
    input  logic [REG_AW_P-1:0] idex_rt,
    input  logic [REG_AW_P-1:0] ifid_rs,
    input  logic [REG_AW_P-1:0] ifid_rt,
    input  logic              ifid_uses_rt,
    input  logic              flush,
    output logic              hazard_stall,
    output logic              pc_write,
    output logic              ifid_write
);

    logic rs_match;
    logic rt_match;

    always_comb begin
        rs_match = (idex_rt == ifid_rs);
        rt_match = ifid_uses_rt && (idex_rt == ifid_rt);
        // $0 is never really written, so a load to it cannot create a dependency.
        // A flush squashes the dependent instruction anyway, so the redirect must not be held.
        hazard_stall = idex_memread && (idex_rt != '0) && (rs_match || rt_match) && !flush;
        pc_write     = !hazard_stall;
        ifid_write   = !hazard_stall;
    end

endmodule

// File: rtl/idex_stage.sv
// idex_stage: ID/EX pipeline register with load-use hazard handling.
// Ports:
//   clk, reset                     clock, async active-high reset
//   flush                          squash the instruction in ID
//   ifid_rs/rt/rd, ifid_uses_rt    register specifiers of the ID instruction
//   id_rdata1/2, id_imm, id_ctrl   decoded operands and control bundle
//   IDEXregRs/Rt/Rd                registered specifiers (to forwarding unit)
//   idex_rdata1/2, idex_imm        registered operands
//   idex_ctrl                      registered control bundle
//   pc_write, ifid_write           stall controls (combinational)
//   hazard_stall                   bubble inserted because of load-use
//   bubble_count                   saturating count of load-use bubbles
module idex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int REG_AW_P = REG_AW,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic [REG_AW_P-1:0] ifid_rs,
    input  logic [REG_AW_P-1:0] ifid_rt,
    input  logic [REG_AW_P-1:0] ifid_rd,
    input  logic                ifid_uses_rt,
    input  logic [DATA_W_P-1:0] id_rdata1,
    input  logic [DATA_W_P-1:0] id_rdata2,
    input  logic [DATA_W_P-1:0] id_imm,
    input  logic [CTRL_W-1:0]   id_ctrl,
    output logic [REG_AW_P-1:0] IDEXregRs,
    output logic [REG_AW_P-1:0] IDEXregRt,
    output logic [REG_AW_P-1:0] IDEXregRd,
    output logic [DATA_W_P-1:0] idex_rdata1,
    output logic [DATA_W_P-1:0] idex_rdata2,
    output logic [DATA_W_P-1:0] idex_imm,
    output logic [CTRL_W-1:0]   idex_ctrl,
    output logic                pc_write,
    output logic                ifid_write,
    output logic                hazard_stall,
    output logic [CNT_W-1:0]    bubble_count
);

    logic [REG_AW_P-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [DATA_W_P-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d, imm_q, imm_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                stall;

    hazard_detect #(.REG_AW_P(REG_AW_P)) u_hazard (
        .idex_memread (ctrl_q[CTRL_MEMREAD]),
        .idex_rt      (rt_q),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .ifid_uses_rt (ifid_uses_rt),
        .flush        (flush),
        .hazard_stall (stall),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write)
    );

    always_comb begin
        // Bubble: zero specifiers keep the forwarding unit from ever matching it.
        rs_d     = '0;
        rt_d     = '0;
        rd_d     = '0;
        rdata1_d = '0;
        rdata2_d = '0;
        imm_d    = '0;
        ctrl_d   = CTRL_NOP;
        if (!flush && !stall) begin
            rs_d     = ifid_rs;
            rt_d     = ifid_rt;
            rd_d     = ifid_rd;
            rdata1_d = id_rdata1;
            rdata2_d = id_rdata2;
            imm_d    = id_imm;
            ctrl_d   = id_ctrl;
        end

        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            ctrl_q   <= CTRL_NOP;
            cnt_q    <= '0;
        end else begin
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            imm_q    <= imm_d;
            ctrl_q   <= ctrl_d;
            cnt_q    <= cnt_d;
        end
    end

    assign IDEXregRs    = rs_q;
    assign IDEXregRt    = rt_q;
    assign IDEXregRd    = rd_q;
    assign idex_rdata1  = rdata1_q;
    assign idex_rdata2  = rdata2_q;
    assign idex_imm     = imm_q;
    assign idex_ctrl    = ctrl_q;
    assign hazard_stall = stall;
    assign bubble_count = cnt_q;

endmodule

// File: tb/tb_idex_stage.sv
// tb_idex_stage: directed self-checking bench for idex_stage.
// The counter is built 2 bits wide so saturation is reached after a few hazards.
module tb_idex_stage;

    localparam int CW = 2;

    localparam logic [8:0] C_RTYPE = 9'h10A;  // RegWrite, RegDst, ALUOp=10
    localparam logic [8:0] C_LW    = 9'h1D0;  // RegWrite, MemtoReg, MemRead, ALUSrc
    localparam logic [8:0] C_ADDI  = 9'h110;  // RegWrite, ALUSrc
    localparam logic [8:0] C_BEQ   = 9'h005;  // Branch, ALUOp=01

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [4:0]  ifid_rs, ifid_rt, ifid_rd;
    logic        ifid_uses_rt;
    logic [31:0] id_rdata1, id_rdata2, id_imm;
    logic [8:0]  id_ctrl;
    logic [4:0]  IDEXregRs, IDEXregRt, IDEXregRd;
    logic [31:0] idex_rdata1, idex_rdata2, idex_imm;
    logic [8:0]  idex_ctrl;
    logic        pc_write, ifid_write, hazard_stall;
    logic [CW-1:0] bubble_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    idex_stage #(.CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .ifid_rd      (ifid_rd),
        .ifid_uses_rt (ifid_uses_rt),
        .id_rdata1    (id_rdata1),
        .id_rdata2    (id_rdata2),
        .id_imm       (id_imm),
        .id_ctrl      (id_ctrl),
        .IDEXregRs    (IDEXregRs),
        .IDEXregRt    (IDEXregRt),
        .IDEXregRd    (IDEXregRd),
        .idex_rdata1  (idex_rdata1),
        .idex_rdata2  (idex_rdata2),
        .idex_imm     (idex_imm),
        .idex_ctrl    (idex_ctrl),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .hazard_stall (hazard_stall),
        .bubble_count (bubble_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic urt, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] imm, input logic [8:0] ctrl);
        ifid_rs = rs; ifid_rt = rt; ifid_rd = rd; ifid_uses_rt = urt;
        id_rdata1 = r1; id_rdata2 = r2; id_imm = imm; id_ctrl = ctrl;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_ctrl"}, 64'(idex_ctrl), 64'h0);
        chk({tag, "_rs"},   64'(IDEXregRs), 64'h0);
        chk({tag, "_rt"},   64'(IDEXregRt), 64'h0);
        chk({tag, "_rd"},   64'(IDEXregRd), 64'h0);
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        set_id(5'd9, 5'd9, 5'd9, 1'b1, 32'hDEAD, 32'hBEEF, 32'h1234, C_RTYPE);
        tick();
        tick();
        chk_bubble("reset");
        chk("reset_rdata1", 64'(idex_rdata1), 64'h0);
        chk("reset_imm",    64'(idex_imm),    64'h0);
        chk("reset_cnt",    64'(bubble_count), 64'h0);
        reset = 1'b0;

        // add $3,$1,$2 then add $4,$3,$1
        set_id(5'd1, 5'd2, 5'd3, 1'b1, 32'h11, 32'h22, 32'h0, C_RTYPE);
        settle();
        chk("add1_pcw", 64'(pc_write), 64'h1);
        tick();
        chk("add1_rs",   64'(IDEXregRs),   64'd1);
        chk("add1_rt",   64'(IDEXregRt),   64'd2);
        chk("add1_rd",   64'(IDEXregRd),   64'd3);
        chk("add1_rd1",  64'(idex_rdata1), 64'h11);
        chk("add1_rd2",  64'(idex_rdata2), 64'h22);
        chk("add1_ctrl", 64'(idex_ctrl),   64'(C_RTYPE));
        set_id(5'd3, 5'd1, 5'd4, 1'b1, 32'h33, 32'h11, 32'h0, C_RTYPE);
        settle();
        chk("add2_pcw", 64'(pc_write), 64'h1);
        tick();
        chk("add2_rd", 64'(IDEXregRd), 64'd4);

        // lw $5,4($1) then add $6,$5,$7 : one bubble
        set_id(5'd1, 5'd5, 5'd0, 1'b0, 32'h100, 32'h0, 32'h4, C_LW);
        tick();
        chk("lw_rt",   64'(IDEXregRt), 64'd5);
        chk("lw_ctrl", 64'(idex_ctrl), 64'(C_LW));
        chk("lw_imm",  64'(idex_imm),  64'h4);
        set_id(5'd5, 5'd7, 5'd6, 1'b1, 32'h55, 32'h77, 32'h0, C_RTYPE);
        settle();
        chk("lu_stall", 64'(hazard_stall), 64'h1);
        chk("lu_pcw",   64'(pc_write),     64'h0);
        chk("lu_ifidw", 64'(ifid_write),   64'h0);
        tick();
        chk_bubble("lu_bub");
        chk("lu_bub_rd1",   64'(idex_rdata1),  64'h0);
        chk("lu_bub_cnt",   64'(bubble_count), 64'd1);
        chk("lu_bub_stall", 64'(hazard_stall), 64'h0);
        chk("lu_bub_pcw",   64'(pc_write),     64'h1);
        tick();
        chk("lu_go_rs",   64'(IDEXregRs), 64'd5);
        chk("lu_go_rd",   64'(IDEXregRd), 64'd6);
        chk("lu_go_ctrl", 64'(idex_ctrl), 64'(C_RTYPE));
        chk("lu_go_cnt",  64'(bubble_count), 64'd1);

        // lw $5 then addi with rt=5 that is not a source : no stall
        set_id(5'd1, 5'd5, 5'd0, 1'b0, 32'h100, 32'h0, 32'h4, C_LW);
        tick();
        set_id(5'd0, 5'd5, 5'd0, 1'b0, 32'h0, 32'h0, 32'h9, C_ADDI);
        settle();
        chk("addi_stall", 64'(hazard_stall), 64'h0);
        chk("addi_pcw",   64'(pc_write),     64'h1);
        tick();
        chk("addi_ctrl", 64'(idex_ctrl), 64'(C_ADDI));
        chk("addi_imm",  64'(idex_imm),  64'h9);

        // lw $0 then add $7,$0,$0 : no stall
        set_id(5'd1, 5'd0, 5'd0, 1'b0, 32'h100, 32'h0, 32'h8, C_LW);
        tick();
        set_id(5'd0, 5'd0, 5'd7, 1'b1, 32'h0, 32'h0, 32'h0, C_RTYPE);
        settle();
        chk("lw0_stall", 64'(hazard_stall), 64'h0);
        tick();
        chk("lw0_rd",  64'(IDEXregRd),    64'd7);
        chk("lw0_cnt", 64'(bubble_count), 64'd1);

        // lw $5 then beq $5,$2 with flush : flush wins
        set_id(5'd1, 5'd5, 5'd0, 1'b0, 32'h100, 32'h0, 32'h4, C_LW);
        tick();
        set_id(5'd5, 5'd2, 5'd0, 1'b1, 32'h55, 32'h22, 32'h10, C_BEQ);
        flush = 1'b1;
        settle();
        chk("fl_stall", 64'(hazard_stall), 64'h0);
        chk("fl_pcw",   64'(pc_write),     64'h1);
        tick();
        flush = 1'b0;
        chk_bubble("fl_bub");
        chk("fl_cnt", 64'(bubble_count), 64'd1);

        // reset asserted in the middle of a stall
        set_id(5'd1, 5'd5, 5'd0, 1'b0, 32'h100, 32'h0, 32'h4, C_LW);
        tick();
        set_id(5'd5, 5'd7, 5'd6, 1'b1, 32'h55, 32'h77, 32'h0, C_RTYPE);
        settle();
        chk("mr_stall", 64'(hazard_stall), 64'h1);
        reset = 1'b1;
        settle();
        chk_bubble("mr_async");
        chk("mr_imm",  64'(idex_imm),     64'h0);
        chk("mr_cnt",  64'(bubble_count), 64'h0);
        chk("mr_pcw",  64'(pc_write),     64'h1);
        tick();
        reset = 1'b0;
        settle();
        chk("mr_rel_pcw", 64'(pc_write), 64'h1);
        tick();
        chk("mr_rel_rs", 64'(IDEXregRs), 64'd5);

        // saturation of the 2-bit counter over four hazards
        for (int i = 0; i < 4; i++) begin
            set_id(5'd1, 5'd5, 5'd0, 1'b0, 32'h100, 32'h0, 32'h4, C_LW);
            tick();
            set_id(5'd5, 5'd7, 5'd6, 1'b1, 32'h55, 32'h77, 32'h0, C_RTYPE);
            settle();
            chk("sat_stall", 64'(hazard_stall), 64'h1);
            tick();
            chk("sat_cnt", 64'(bubble_count), 64'((i + 1 > 3) ? 3 : i + 1));
            tick();
        end
        chk("sat_hold", 64'(bubble_count), 64'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
